sound_sequencer: RTL and testbench
==================================

Name: sound_sequencer

Overview:
- Command-side initiator for the buzzer's CPU-Sound interface; it drives the 26-bit max_count bus and the 1-cycle latch_max_count strobe that the buzzer consumes.
- The CPU pushes notes into a small FIFO; each note is a half-period count plus a duration in milliseconds.
- The block plays the notes back-to-back without CPU involvement, then latches silence (max_count = 0).
- It sits between the CPU's I/O decode and the buzzer.

Parameters:
- FIFO_DEPTH, 8, number of queued notes; must be a power of 2, at least 2.
- TICKS_PER_MS, 50000, clk cycles per millisecond at 50 MHz; benches override it to 10.

Ports:
- clk  input  1  50 MHz system clock.
- rst_async  input  1  asynchronous, active-high reset.
- note_max_count  input  26  half-period count for the pushed note; 0 means a rest.
- note_duration_ms  input  16  note length in ms.
- note_push  input  1  1-cycle strobe that enqueues {note_max_count, note_duration_ms}.
- stop  input  1  1-cycle strobe that flushes the queue and silences the buzzer.
- fifo_full  output  1  queue holds FIFO_DEPTH entries.
- overflow  output  1  sticky; set when a push arrives while full.
- busy  output  1  FSM is not in IDLE.
- max_count  output  26  registered command to the buzzer.
- latch_max_count  output  1  registered 1-cycle latch strobe to the buzzer.

Behaviour:
- Reset:
  - All outputs are 0, FIFO is empty, FSM is in IDLE, prescaler and duration counters are 0.
  - Asserting reset mid-note abandons the note immediately. No silence latch is issued; the buzzer has its own reset.
- Push rule:
  - A push is accepted iff fifo_full = 0 at the sampling edge. A pop in the same cycle does not free a slot.
  - A rejected push sets overflow. overflow clears only on reset.
- FSM states:
  - IDLE: when FIFO is non-empty, go to LATCH.
  - LATCH (1 cycle): pop the head entry; register max_count <= entry.max_count and latch_max_count <= 1; load dur <= entry.duration; clear prescaler.
    - If entry.duration != 0, go to PLAY.
    - Otherwise go to LATCH if FIFO has another entry, else SILENCE.
  - PLAY:
    - Prescaler counts 0..TICKS_PER_MS-1. On wrap, dur decrements.
    - When dur reaches 0 on a wrap, go to LATCH if FIFO is non-empty, else SILENCE.
    - PLAY therefore lasts exactly duration*TICKS_PER_MS cycles.
  - SILENCE (1 cycle): max_count <= 0, latch_max_count <= 1, go to IDLE.
- Outputs:
  - latch_max_count is high for exactly one cycle per LATCH or SILENCE.
  - max_count holds its last latched value between strobes.
  - busy = (state != IDLE).
- Latency: a push at edge N into an empty FIFO with the FSM in IDLE gives latch_max_count = 1 during cycle N+2.
- Note spacing: consecutive latch strobes are 1 + D*TICKS_PER_MS cycles apart, where D is the earlier note's duration.
- stop:
  - Highest priority. At the edge it flushes the FIFO and drops any push in the same cycle without setting overflow.
  - If busy, or if max_count != 0, the FSM enters SILENCE next; otherwise it stays in IDLE.
- Push in the same cycle the FSM pops: accepted if not full; the FIFO count is unchanged.
- Arithmetic:
  - FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally; the count is log2(FIFO_DEPTH)+1 bits.
  - dur is 16 bits and decrements only when dur != 0.
  - The prescaler is $clog2(TICKS_PER_MS) bits.

Decomposition:
- Shared package sound_pkg holds:
  - MAX_COUNT_W = 26 and DURATION_W = 16;
  - typedef note_t, a packed struct {max_count, duration_ms};
  - typedef seq_state_t, an enum {IDLE, LATCH, PLAY, SILENCE}.
- Sub-module note_fifo: synchronous FIFO of note_t with push, pop, flush, full, empty and head outputs; the head is visible combinationally.

Test Plan (TICKS_PER_MS = 10):
- Single note: push {1000, 3} at cycle 0.
  - latch=1 with max_count=1000 at cycle 2.
  - SILENCE latch with max_count=0 at cycle 33.
  - busy falls at cycle 34.
- Back-to-back notes: push {500, 2}, {0, 1}, {700, 1}.
  - Latches at cycles t, t+21, t+32, then a silence latch at t+43.
  - The rest latches max_count=0 mid-sequence.
- Zero duration: push {123, 0}, {456, 2}.
  - Latches of 123 and 456 on consecutive cycles.
  - Silence latch 21 cycles after the 456 latch.
- Overflow: push 9 notes while the FSM holds in PLAY on a long note.
  - fifo_full=1 after the 8th push; the 9th push sets overflow=1 and is dropped.
  - Exactly 8 latches occur, plus the one already playing.
- Stop mid-play: during PLAY with 3 notes queued, pulse stop together with a push.
  - Next cycle gives latch=1 with max_count=0, then IDLE, empty FIFO, overflow still 0.
  - No further latches over the next 100 cycles.
- Reset mid-note: assert rst_async asynchronously during PLAY.
  - All outputs drop to 0 immediately.
  - After release, no latch occurs until a new push.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types for the buzzer note sequencer: note record layout and FSM states.
package sound_pkg;

  localparam int MAX_COUNT_W = 26;
  localparam int DURATION_W  = 16;

  typedef struct packed {
    logic [MAX_COUNT_W-1:0] max_count;
    logic [DURATION_W-1:0]  duration_ms;
  } note_t;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    PLAY,
    SILENCE
  } seq_state_t;

endpackage

// File: rtl/note_fifo.sv
// Synchronous note queue with a combinationally visible head and a flush that
// overrides push and pop.
module note_fifo
  import sound_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_async,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  note_t                  push_data,
  output note_t                  head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  note_t           mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Plays queued notes to the buzzer back-to-back: latches each half-period
// count for its duration, then latches silence once the queue drains.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int TICKS_PER_MS = 50000
) (
  input  logic                   clk,
  input  logic                   rst_async,
  input  logic [MAX_COUNT_W-1:0] note_max_count,
  input  logic [DURATION_W-1:0]  note_duration_ms,
  input  logic                   note_push,
  input  logic                   stop,
  output logic                   fifo_full,
  output logic                   overflow,
  output logic                   busy,
  output logic [MAX_COUNT_W-1:0] max_count,
  output logic                   latch_max_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);

  seq_state_t             state_reg;
  logic [MAX_COUNT_W-1:0] max_count_reg;
  logic                   latch_reg;
  logic                   busy_reg;
  logic                   overflow_reg;
  logic [DURATION_W-1:0]  dur_reg;
  logic [PW-1:0]          presc_reg;

  note_t          push_note;
  note_t          head;
  logic           fifo_empty;
  logic           fifo_full_int;
  logic [CW-1:0]  fifo_count;
  logic           push_ok;
  logic           pop;
  logic           more_after_pop;
  logic           more_waiting;

  assign push_note = {note_max_count, note_duration_ms};
  assign push_ok   = note_push && !fifo_full_int && !stop;
  assign pop       = (state_reg == LATCH) && !stop;

  // Queue occupancy as it will be after this edge, so a push landing on the
  // decision edge chains straight into the next note instead of a silence.
  assign more_after_pop = (fifo_count > CW'(1)) || push_ok;
  assign more_waiting   = !fifo_empty || push_ok;

  note_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_async (rst_async),
    .push      (push_ok),
    .pop       (pop),
    .flush     (stop),
    .push_data (push_note),
    .head      (head),
    .full      (fifo_full_int),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_reg     <= IDLE;
      max_count_reg <= '0;
      latch_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      dur_reg       <= '0;
      presc_reg     <= '0;
    end else begin
      latch_reg <= 1'b0;
      busy_reg  <= (state_reg != IDLE);
      if (note_push && fifo_full_int && !stop) begin
        overflow_reg <= 1'b1;
      end

      if (stop) begin
        presc_reg <= '0;
        dur_reg   <= '0;
        if ((state_reg != IDLE) || (max_count_reg != '0)) begin
          state_reg <= SILENCE;
        end else begin
          state_reg <= IDLE;
        end
      end else begin
        case (state_reg)
          IDLE: begin
            if (!fifo_empty) begin
              state_reg <= LATCH;
            end
          end
          LATCH: begin
            max_count_reg <= head.max_count;
            latch_reg     <= 1'b1;
            dur_reg       <= head.duration_ms;
            presc_reg     <= '0;
            if (head.duration_ms != '0) begin
              state_reg <= PLAY;
            end else if (more_after_pop) begin
              state_reg <= LATCH;
            end else begin
              state_reg <= SILENCE;
            end
          end
          PLAY: begin
            if (presc_reg == PRESC_LAST) begin
              presc_reg <= '0;
              if (dur_reg != '0) begin
                dur_reg <= dur_reg - DURATION_W'(1);
              end
              if (dur_reg <= DURATION_W'(1)) begin
                state_reg <= more_waiting ? LATCH : SILENCE;
              end
            end else begin
              presc_reg <= presc_reg + PW'(1);
            end
          end
          SILENCE: begin
            max_count_reg <= '0;
            latch_reg     <= 1'b1;
            state_reg     <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign fifo_full       = fifo_full_int;
  assign overflow        = overflow_reg;
  assign busy            = busy_reg;
  assign max_count       = max_count_reg;
  assign latch_max_count = latch_reg;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: directed scenarios plus random traffic, every
// cycle compared against an event-time model of the note schedule.
module tb_sound_sequencer;

  localparam int DEPTH = 8;
  localparam int T     = 10;

  logic        clk = 1'b0;
  logic        rst_async = 1'b1;
  logic [25:0] note_max_count = '0;
  logic [15:0] note_duration_ms = '0;
  logic        note_push = 1'b0;
  logic        stop = 1'b0;
  logic        fifo_full;
  logic        overflow;
  logic        busy;
  logic [25:0] max_count;
  logic        latch_max_count;

  always #5 clk = ~clk;

  sound_sequencer #(
    .FIFO_DEPTH   (DEPTH),
    .TICKS_PER_MS (T)
  ) dut (
    .clk              (clk),
    .rst_async        (rst_async),
    .note_max_count   (note_max_count),
    .note_duration_ms (note_duration_ms),
    .note_push        (note_push),
    .stop             (stop),
    .fifo_full        (fifo_full),
    .overflow         (overflow),
    .busy             (busy),
    .max_count        (max_count),
    .latch_max_count  (latch_max_count)
  );

  typedef struct {
    int unsigned mc;
    int unsigned dur;
  } note_s;

  // Model: queued notes plus the edge index of the next scheduled latch.
  note_s       q[$];
  int          n = 0;
  bit          active = 0;
  bit          eng = 0;
  bit          evt_sil = 0;
  int          next_evt = -1;
  int          decide_at = -1;
  int          start_edge = 0;
  logic [25:0] exp_max = '0;
  bit          exp_latch = 0;
  bit          exp_busy = 0;
  bit          exp_full = 0;
  bit          exp_ovf = 0;

  int checks = 0;
  int passes = 0;
  int latch_cnt = 0;

  task automatic check_eq(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, expv, n);
  endtask

  function automatic void model_reset();
    q.delete();
    active = 0; eng = 0; evt_sil = 0;
    next_evt = -1; decide_at = -1; start_edge = 0;
    exp_max = '0; exp_latch = 0; exp_busy = 0; exp_full = 0; exp_ovf = 0;
  endfunction

  function automatic void model_step(input bit push, input int unsigned mc,
                                     input int unsigned dur, input bit stp);
    bit    full_before;
    bit    sil;
    note_s nt;
    n++;
    exp_latch   = 0;
    exp_busy    = eng;
    full_before = (q.size() == DEPTH);
    if (stp) begin
      sil = eng || (exp_max != '0);
      q.delete();
      active = sil;
      if (sil) begin
        evt_sil = 1; next_evt = n + 1; decide_at = -1; start_edge = n;
      end
    end else begin
      if (push && full_before) exp_ovf = 1;
      if (active && next_evt == n) begin
        if (evt_sil || q.size() == 0) begin
          exp_max = '0; exp_latch = 1; active = 0;
        end else begin
          nt = q.pop_front();
          exp_max   = nt.mc[25:0];
          exp_latch = 1;
          next_evt  = n + 1 + int'(nt.dur) * T;
          decide_at = n + int'(nt.dur) * T;
        end
      end
      if (push && !full_before) begin
        nt.mc = mc; nt.dur = dur;
        q.push_back(nt);
      end
      if (active && n == decide_at) evt_sil = (q.size() == 0);
      if (!active && q.size() > 0) begin
        active = 1; evt_sil = 0; next_evt = n + 2; decide_at = -1; start_edge = n + 1;
      end
    end
    exp_full = (q.size() == DEPTH);
    eng = active && (n >= start_edge);
  endfunction

  always @(posedge clk or posedge rst_async) begin
    if (rst_async) model_reset();
    else model_step(note_push, int'(note_max_count), int'(note_duration_ms), stop);
  end

  always @(negedge clk) begin
    check_eq("latch", latch_max_count, exp_latch);
    check_eq("max_count", max_count, exp_max);
    check_eq("busy", busy, exp_busy);
    check_eq("fifo_full", fifo_full, exp_full);
    check_eq("overflow", overflow, exp_ovf);
    if (latch_max_count) begin
      latch_cnt++;
      $display("edge %0d: latch max_count=%0d", n, max_count);
    end
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic push_note(input int unsigned mc, input int unsigned dur);
    note_max_count   = mc[25:0];
    note_duration_ms = dur[15:0];
    note_push        = 1'b1;
    tick(1);
    note_push        = 1'b0;
  endtask

  initial begin
    tick(3);
    rst_async = 1'b0;
    tick(2);

    // single note, then back-to-back with a rest, then zero-duration chaining
    push_note(1000, 3);
    tick(40);
    push_note(500, 2); push_note(0, 1); push_note(700, 1);
    tick(60);
    push_note(123, 0); push_note(456, 2);
    tick(40);

    // overflow while a long note holds the player
    latch_cnt = 0;
    push_note(9999, 10);
    tick(4);
    for (int i = 0; i < 8; i++) push_note(100 + i, 1);
    check_eq("full_after_8", fifo_full, 1);
    push_note(4242, 1);
    check_eq("overflow_after_9", overflow, 1);
    tick(250);
    check_eq("ovf_phase_latches", latch_cnt, 10);

    // stop with a simultaneous push during playback (reset clears sticky overflow)
    rst_async = 1'b1; tick(1); rst_async = 1'b0; tick(1);
    push_note(1111, 5);
    push_note(10, 1); push_note(20, 1); push_note(30, 1);
    tick(15);
    note_max_count = 26'd77; note_duration_ms = 16'd1;
    note_push = 1'b1; stop = 1'b1;
    tick(1);
    note_push = 1'b0; stop = 1'b0;
    latch_cnt = 0;
    tick(100);
    check_eq("stop_latches", latch_cnt, 1);
    check_eq("stop_overflow", overflow, 0);

    // asynchronous reset in the middle of a note
    push_note(2222, 4);
    tick(10);
    @(posedge clk); #3;
    rst_async = 1'b1;
    #1;
    check_eq("async_rst_latch", latch_max_count, 0);
    check_eq("async_rst_max", max_count, 0);
    check_eq("async_rst_busy", busy, 0);
    tick(1);
    rst_async = 1'b0;
    latch_cnt = 0;
    tick(30);
    check_eq("post_rst_latches", latch_cnt, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      note_push = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 199) == 0);
      note_max_count   = ($urandom_range(0, 3) == 0) ? 26'd0 : 26'($urandom_range(1, 26'h3FFFFFF));
      note_duration_ms = 16'($urandom_range(0, 3));
      tick(1);
    end
    note_push = 1'b0;
    stop = 1'b0;
    tick(200);
    check_eq("final_busy", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
